spike_group_encoder: RTL and testbench

- Downstream consumer of the serial-to-parallel spike stage. Takes each P-bit parallel spike group with its valid and active flags, discards inactive groups and queues active ones in a small FIFO.
- Emits one address-event per set spike bit over a valid/ready interface towards the neuron update engine.
- Tracks the group position inside a timestep and marks the end of each timestep, so downstream sees frame boundaries even when the timestep ends silently.

---
 rtl/spike_group_encoder.sv | 182 ++++++++++++++++++
 tb/tb_spike_group_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_group_encoder.sv
// rtl/spike_group_encoder.sv - queues active spike groups and emits one address-event per set spike bit
module spike_group_encoder #(
   parameter int P        = 2,
   parameter int N_GROUPS = 8,
   parameter int DEPTH    = 4,
   localparam int ADDR_W  = $clog2(P * N_GROUPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [P-1:0]      in_spikes,
   input  logic              in_active,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [ADDR_W-1:0] evt_addr,
   output logic              evt_eof,
   output logic              evt_null,
   output logic              overflow,
   input  logic              clr_ovf,
   output logic              busy
);

   localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int BW = (P > 1) ? $clog2(P) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   // group position within the timestep
   logic [GW-1:0] gidx_q;
   logic          last_grp;

   // FIFO storage and bookkeeping
   logic [P-1:0]  mem_mask [DEPTH];
   logic [GW-1:0] mem_gidx [DEPTH];
   logic          mem_last [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          want_push, fifo_full, push, push_rej, pop;
   logic          overflow_q;

   // scanner state and registered event outputs
   state_t            state_q;
   logic [P-1:0]      mask_q;
   logic [GW-1:0]     egidx_q;
   logic              elast_q;
   logic              evt_valid_q, evt_eof_q, evt_null_q;
   logic [ADDR_W-1:0] evt_addr_q;
   logic              hs, load;

   // next event derived from either the FIFO head or the remaining mask
   logic [P-1:0]      src_mask, rem_mask;
   logic [GW-1:0]     src_gidx;
   logic              src_last;
   logic [BW-1:0]     bit_idx;
   logic [ADDR_W-1:0] nxt_addr;
   logic              nxt_eof, nxt_null;

   assign last_grp  = (gidx_q == GW'(N_GROUPS - 1));
   assign want_push = in_valid & (in_active | last_grp);
   // no bypass: a pop in the same cycle does not make room for a push
   assign fifo_full = (count_q == CW'(DEPTH));
   assign push      = want_push & ~fifo_full;
   assign push_rej  = want_push & fifo_full;

   assign hs   = evt_valid_q & evt_ready;
   // pop when idle, or when the entry being scanned just gave its last bit away
   assign pop  = (count_q != '0) & ((state_q == IDLE) | (hs & (mask_q == '0)));
   assign load = pop | (mask_q != '0);

   assign src_mask = pop ? mem_mask[rd_ptr_q] : mask_q;
   assign src_gidx = pop ? mem_gidx[rd_ptr_q] : egidx_q;
   assign src_last = pop ? mem_last[rd_ptr_q] : elast_q;

   // pick the highest set bit (earliest serial arrival) and build its event
   always_comb begin
      bit_idx  = '0;
      rem_mask = src_mask;
      nxt_addr = '0;
      nxt_eof  = 1'b0;
      nxt_null = 1'b0;
      for (int i = 0; i < P; i++) begin
         if (src_mask[i]) bit_idx = BW'(i);
      end
      rem_mask[bit_idx] = 1'b0;
      if (src_mask == '0) begin
         nxt_null = 1'b1;
         nxt_eof  = 1'b1;
      end else begin
         nxt_addr = ADDR_W'(src_gidx) * ADDR_W'(P) + ADDR_W'(P - 1) - ADDR_W'(bit_idx);
         nxt_eof  = src_last & (rem_mask == '0);
      end
   end

   // occupancy after this cycle's push and pop
   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // FIFO payload write; contents need no reset since count gates reads
   always_ff @(posedge clk) begin
      if (push) begin
         mem_mask[wr_ptr_q] <= in_spikes;
         mem_gidx[wr_ptr_q] <= gidx_q;
         mem_last[wr_ptr_q] <= last_grp;
      end
   end

   // group counter, FIFO pointers and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         gidx_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (in_valid) gidx_q <= last_grp ? '0 : gidx_q + 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push_rej) overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   // scanner FSM with registered event outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         egidx_q     <= '0;
         elast_q     <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_addr_q  <= '0;
         evt_eof_q   <= 1'b0;
         evt_null_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  mask_q      <= rem_mask;
                  egidx_q     <= src_gidx;
                  elast_q     <= src_last;
                  evt_valid_q <= 1'b1;
                  evt_addr_q  <= nxt_addr;
                  evt_eof_q   <= nxt_eof;
                  evt_null_q  <= nxt_null;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               if (hs) begin
                  if (load) begin
                     mask_q      <= rem_mask;
                     egidx_q     <= src_gidx;
                     elast_q     <= src_last;
                     evt_addr_q  <= nxt_addr;
                     evt_eof_q   <= nxt_eof;
                     evt_null_q  <= nxt_null;
                  end else begin
                     evt_valid_q <= 1'b0;
                     evt_eof_q   <= 1'b0;
                     evt_null_q  <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_addr  = evt_addr_q;
   assign evt_eof   = evt_eof_q;
   assign evt_null  = evt_null_q;
   assign overflow  = overflow_q;
   assign busy      = (count_q != '0) | evt_valid_q;

endmodule

// File: tb/tb_spike_group_encoder.sv
// tb/tb_spike_group_encoder.sv - directed self-checking bench for spike_group_encoder
module tb_spike_group_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_spikes;
   logic       in_active;
   logic       evt_ready;
   logic       evt_valid;
   logic [3:0] evt_addr;
   logic       evt_eof;
   logic       evt_null;
   logic       overflow;
   logic       clr_ovf;
   logic       busy;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   int log_addr[$];
   int log_eof[$];
   int log_null[$];
   int log_cyc[$];

   spike_group_encoder #(.P(4), .N_GROUPS(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_spikes(in_spikes),
      .in_active(in_active), .evt_ready(evt_ready), .evt_valid(evt_valid),
      .evt_addr(evt_addr), .evt_eof(evt_eof), .evt_null(evt_null),
      .overflow(overflow), .clr_ovf(clr_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic clear_log();
      log_addr.delete(); log_eof.delete(); log_null.delete(); log_cyc.delete();
   endtask

   // record a handshake that the coming edge will complete, then advance one cycle
   task automatic step();
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
         log_addr.push_back(int'(evt_addr));
         log_eof.push_back(int'(evt_eof));
         log_null.push_back(int'(evt_null));
         log_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [3:0] s);
      in_valid  = 1'b1;
      in_spikes = s;
      in_active = |s;
      step();
      in_valid  = 1'b0;
      in_spikes = 4'b0;
      in_active = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((busy === 1'b1 || evt_valid === 1'b1) && n < 60) begin
         step();
         n++;
      end
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL %s drain: busy=%b required 0 within 60 cycles", name, busy);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (evt_valid !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      nvec++;
      if (evt_valid !== 1'b1) begin
         nerr++;
         $display("FAIL %s wait_valid: evt_valid=%b required 1 within 10 cycles", name, evt_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      nvec++; if (evt_valid !== 1'b0) begin nerr++; $display("FAIL reset evt_valid: got %b want 0", evt_valid); end
      nvec++; if (evt_addr !== 4'd0) begin nerr++; $display("FAIL reset evt_addr: got %0d want 0", evt_addr); end
      nvec++; if (evt_eof !== 1'b0) begin nerr++; $display("FAIL reset evt_eof: got %b want 0", evt_eof); end
      nvec++; if (evt_null !== 1'b0) begin nerr++; $display("FAIL reset evt_null: got %b want 0", evt_null); end
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset overflow: got %b want 0", overflow); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_frame_null();
      int ea[5] = '{0, 3, 9, 10, 0};
      int ee[5] = '{0, 0, 0, 0, 1};
      int en[5] = '{0, 0, 0, 0, 1};
      clear_log();
      evt_ready = 1'b1;
      send(4'b1001); send(4'b0000); send(4'b0110); send(4'b0000);
      drain("frame_null");
      nvec++;
      if (log_addr.size() != 5) begin
         nerr++; $display("FAIL frame_null count: got %0d events want 5", log_addr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            nvec++;
            if (log_addr[i] != ea[i] || log_eof[i] != ee[i] || log_null[i] != en[i]) begin
               nerr++;
               $display("FAIL frame_null ev%0d: got addr=%0d eof=%0d null=%0d want addr=%0d eof=%0d null=%0d",
                        i, log_addr[i], log_eof[i], log_null[i], ea[i], ee[i], en[i]);
            end
         end
      end
   endtask

   task automatic test_frame_last_spike();
      int ea[5] = '{0, 3, 9, 10, 15};
      int ee[5] = '{0, 0, 0, 0, 1};
      clear_log();
      evt_ready = 1'b1;
      send(4'b1001); send(4'b0000); send(4'b0110); send(4'b0001);
      drain("last_spike");
      nvec++;
      if (log_addr.size() != 5) begin
         nerr++; $display("FAIL last_spike count: got %0d events want 5", log_addr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            nvec++;
            if (log_addr[i] != ea[i] || log_eof[i] != ee[i] || log_null[i] != 0) begin
               nerr++;
               $display("FAIL last_spike ev%0d: got addr=%0d eof=%0d null=%0d want addr=%0d eof=%0d null=0",
                        i, log_addr[i], log_eof[i], log_null[i], ea[i], ee[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      clear_log();
      evt_ready = 1'b0;
      send(4'b1001);
      wait_valid("stall");
      for (int k = 0; k < 5; k++) begin
         nvec++;
         if (evt_valid !== 1'b1 || evt_addr !== 4'd0 || evt_eof !== 1'b0) begin
            nerr++;
            $display("FAIL stall hold%0d: got valid=%b addr=%0d eof=%b want valid=1 addr=0 eof=0",
                     k, evt_valid, evt_addr, evt_eof);
         end
         step();
      end
      evt_ready = 1'b1;
      drain("stall");
      send(4'b0000); send(4'b0000); send(4'b0000);
      drain("stall_tail");
      nvec++;
      if (log_addr.size() != 3) begin
         nerr++; $display("FAIL stall count: got %0d events want 3", log_addr.size());
      end else begin
         nvec++;
         if (log_addr[0] != 0 || log_addr[1] != 3 || log_null[0] != 0 || log_null[2] != 1 || log_eof[2] != 1) begin
            nerr++;
            $display("FAIL stall order: got addr %0d,%0d null2=%0d eof2=%0d want 0,3 null2=1 eof2=1",
                     log_addr[0], log_addr[1], log_null[2], log_eof[2]);
         end
      end
   endtask

   task automatic test_overflow();
      int ea[9] = '{0, 5, 10, 15, 0, 1, 2, 3, 0};
      int ee[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
      int en[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      clear_log();
      evt_ready = 1'b0;
      send(4'b1000); send(4'b0100); send(4'b0010); send(4'b0001); send(4'b1111);
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
      send(4'b1111);
      nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", overflow); end
      nvec++; if (busy !== 1'b1 || evt_valid !== 1'b1 || evt_addr !== 4'd0) begin
         nerr++; $display("FAIL ovf_hold: got busy=%b valid=%b addr=%0d want 1 1 0", busy, evt_valid, evt_addr);
      end
      evt_ready = 1'b1;
      drain("ovf");
      send(4'b0000); send(4'b0000);
      drain("ovf_tail");
      nvec++;
      if (log_addr.size() != 9) begin
         nerr++; $display("FAIL ovf count: got %0d events want 9", log_addr.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            nvec++;
            if (log_addr[i] != ea[i] || log_eof[i] != ee[i] || log_null[i] != en[i]) begin
               nerr++;
               $display("FAIL ovf ev%0d: got addr=%0d eof=%0d null=%0d want addr=%0d eof=%0d null=%0d",
                        i, log_addr[i], log_eof[i], log_null[i], ea[i], ee[i], en[i]);
            end
         end
      end
      nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   task automatic test_reset_midscan();
      clear_log();
      evt_ready = 1'b0;
      send(4'b1111);
      wait_valid("midscan");
      evt_ready = 1'b1;
      step();
      step();
      rst = 1'b1;
      evt_ready = 1'b0;
      step();
      nvec++;
      if (evt_valid !== 1'b0 || evt_addr !== 4'd0 || evt_eof !== 1'b0 || evt_null !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL midscan_rst: got valid=%b addr=%0d eof=%b null=%b busy=%b want all 0",
                  evt_valid, evt_addr, evt_eof, evt_null, busy);
      end
      rst = 1'b0;
      nvec++;
      if (log_addr.size() != 2 || log_addr[0] != 0 || log_addr[1] != 1) begin
         nerr++; $display("FAIL midscan_pre: got %0d events before reset want 2 (addr 0,1)", log_addr.size());
      end
      clear_log();
      evt_ready = 1'b1;
      send(4'b0100);
      drain("midscan_restart");
      nvec++;
      if (log_addr.size() != 1 || log_addr[0] != 1 || log_eof[0] != 0 || log_null[0] != 0) begin
         nerr++;
         $display("FAIL midscan_restart: got %0d events first addr=%0d want 1 event addr=1",
                  log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : -1);
      end
      send(4'b0000); send(4'b0000); send(4'b0000);
      drain("midscan_tail");
   endtask

   task automatic test_back_to_back();
      int ea[5] = '{0, 1, 6, 7, 0};
      int t0;
      clear_log();
      evt_ready = 1'b1;
      t0 = cyc;
      send(4'b1100); send(4'b0011); send(4'b0000); send(4'b0000);
      drain("b2b");
      nvec++;
      if (log_addr.size() != 5) begin
         nerr++; $display("FAIL b2b count: got %0d events want 5", log_addr.size());
      end else begin
         nvec++;
         if (log_cyc[0] != t0 + 2) begin
            nerr++; $display("FAIL b2b latency: first event at cycle %0d want %0d", log_cyc[0], t0 + 2);
         end
         for (int i = 0; i < 5; i++) begin
            nvec++;
            if (log_addr[i] != ea[i] || (i > 0 && log_cyc[i] != log_cyc[i-1] + 1)) begin
               nerr++;
               $display("FAIL b2b ev%0d: got addr=%0d cycle=%0d want addr=%0d on consecutive cycle",
                        i, log_addr[i], log_cyc[i], ea[i]);
            end
         end
         nvec++;
         if (log_null[4] != 1 || log_eof[4] != 1) begin
            nerr++; $display("FAIL b2b marker: got null=%0d eof=%0d want 1 1", log_null[4], log_eof[4]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_spikes = 4'b0; in_active = 1'b0;
      evt_ready = 1'b0; clr_ovf = 1'b0;
      test_reset();
      test_frame_null();
      test_frame_last_spike();
      test_stall();
      test_overflow();
      test_reset_midscan();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
